// File: rtl/inst_dec_queue.sv
// inst_dec_queue: RV32I decode stage feeding a DEPTH-entry queue of decoded instructions.
// Each instruction is decoded in the cycle fetch hands it over. The decoded result is
// stored, and the registered head entry drives execute.
//
// Optional feature: define RV32M_DEC_EN to decode RV32M (op 0110011, funct7 0000001) as muldiv.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   flush              drop all queued entries plus this cycle's push/pop
//   in_valid/in_ready  fetch handshake; in_inst/in_pc are the offered instruction and its PC
//   out_valid/out_ready execute handshake on the queue head
//   out_*              decoded fields of the head entry; out_count is the occupancy
module inst_dec_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PC_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_inst,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              out_pc,
  output logic [6:0]                   out_opcode,
  output logic [12:0]                  out_optype,
  output logic [5:0]                   out_fmt,
  output logic [2:0]                   out_funct3,
  output logic [6:0]                   out_funct7,
  output logic [4:0]                   out_rd,
  output logic [4:0]                   out_rs1,
  output logic [4:0]                   out_rs2,
  output logic [31:0]                  out_imm,
  output logic                         out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   out_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
    logic [12:0]     optype;
    logic [5:0]      fmt;
    logic [31:0]     imm;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StPartial, StFull} occ_e;

  occ_e            state_q, state_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  entry_t          mem_q [DEPTH];
  entry_t          dec;
  logic            full, push, pop;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  assign op = in_inst[6:0];
  assign f3 = in_inst[14:12];
  assign f7 = in_inst[31:25];

  // Decode. fmt bits: 0 R, 1 I, 2 S, 3 B, 4 J, 5 U.
  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.inst    = in_inst;
    unique case (op)
      7'b0110111: begin dec.optype[0] = 1'b1; dec.fmt[5] = 1'b1; end
      7'b0010111: begin dec.optype[1] = 1'b1; dec.fmt[5] = 1'b1; end
      7'b1101111: begin dec.optype[2] = 1'b1; dec.fmt[4] = 1'b1; end
      7'b1100111: begin
        dec.optype[3] = 1'b1; dec.fmt[1] = 1'b1;
        dec.illegal   = (f3 != 3'b000);
      end
      7'b1100011: begin
        dec.optype[4] = 1'b1; dec.fmt[3] = 1'b1;
        dec.illegal   = (f3 == 3'b010) || (f3 == 3'b011);
      end
      7'b0000011: begin
        dec.optype[5] = 1'b1; dec.fmt[1] = 1'b1;
        dec.illegal   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      7'b0010011: begin
        dec.fmt[1] = 1'b1;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.optype[8] = 1'b1;
          // Only srai may carry funct7 0100000.
          dec.illegal = !((f7 == 7'b0000000) || (f7 == 7'b0100000 && f3 == 3'b101));
        end else begin
          dec.optype[6] = 1'b1;
        end
      end
      7'b0100011: begin
        dec.optype[7] = 1'b1; dec.fmt[2] = 1'b1;
        dec.illegal   = (f3 >= 3'b011);
      end
      7'b0110011: begin
        dec.fmt[0] = 1'b1;
        if (f7 == 7'b0000000) begin
          dec.optype[9] = 1'b1;
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          dec.optype[9] = 1'b1;
`ifdef RV32M_DEC_EN
        end else if (f7 == 7'b0000001) begin
          dec.optype[12] = 1'b1;
`endif
        end else begin
          dec.illegal = 1'b1;
        end
      end
      7'b0001111: begin dec.optype[10] = 1'b1; dec.fmt[1] = 1'b1; end
      7'b1110011: begin
        dec.optype[11] = 1'b1; dec.fmt[1] = 1'b1;
        dec.illegal    = (f3 != 3'b000);
      end
      default: dec.illegal = 1'b1;
    endcase
    if (in_inst[1:0] != 2'b11) dec.illegal = 1'b1;
    if (dec.illegal) begin
      dec.optype = '0;
      dec.fmt    = '0;
    end
    // Immediate by format; R-type and illegal entries carry zero.
    unique case (1'b1)
      dec.fmt[1]: dec.imm = {{20{in_inst[31]}}, in_inst[31:20]};
      dec.fmt[2]: dec.imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      dec.fmt[3]: dec.imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                             in_inst[11:8], 1'b0};
      dec.fmt[4]: dec.imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                             in_inst[30:21], 1'b0};
      dec.fmt[5]: dec.imm = {in_inst[31:12], 12'h000};
      default:    dec.imm = '0;
    endcase
  end

  // Full blocks a push even when a pop happens in the same cycle.
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = out_valid && out_ready && !flush;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Occupancy FSM: state register / next state / outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StEmpty;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = StPartial;
    if (flush || count_d == '0)     state_d = StEmpty;
    else if (count_d == CW'(DEPTH)) state_d = StFull;
  end

  always_comb begin
    out_valid = (state_q != StEmpty);
    full      = (state_q == StFull);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      if (push) mem_q[wr_q] <= dec;
    end
  end

  entry_t head;
  assign head        = mem_q[rd_q];
  assign out_pc      = head.pc;
  assign out_opcode  = head.inst[6:0];
  assign out_funct3  = head.inst[14:12];
  assign out_funct7  = head.inst[31:25];
  assign out_rd      = head.inst[11:7];
  assign out_rs1     = head.inst[19:15];
  assign out_rs2     = head.inst[24:20];
  assign out_optype  = head.optype;
  assign out_fmt     = head.fmt;
  assign out_imm     = head.imm;
  assign out_illegal = head.illegal;
  assign out_count   = count_q;

endmodule

// File: tb/tb_inst_dec_queue.sv
module tb_inst_dec_queue;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_inst, in_pc, out_pc, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [12:0] out_optype;
  logic [5:0]  out_fmt;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [1:0]  out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_dec_queue #(.DEPTH(DEPTH), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_optype(out_optype), .out_fmt(out_fmt),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm), .out_illegal(out_illegal), .out_count(out_count)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ment_t;
  typedef struct packed { logic [12:0] ot; logic [5:0] fm; logic [31:0] im; logic il; } dec_t;

  ment_t mq[$];

  // Reference decoder: classify by opcode, then build the immediate arithmetically.
  function automatic dec_t ref_dec(input logic [31:0] i);
    dec_t d;
    int cls, fi;
    bit legal;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [31:0] si;
    logic [31:0] sra20;
    logic [12:0] b;
    logic [20:0] j;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    legal = (i[1:0] == 2'b11);
    cls = 0; fi = 0;
    case (op)
      7'h37: begin cls = 0; fi = 5; end
      7'h17: begin cls = 1; fi = 5; end
      7'h6F: begin cls = 2; fi = 4; end
      7'h67: begin cls = 3; fi = 1; if (f3 != 0) legal = 0; end
      7'h63: begin cls = 4; fi = 3; if (f3 inside {3'd2, 3'd3}) legal = 0; end
      7'h03: begin cls = 5; fi = 1; if (f3 inside {3'd3, 3'd6, 3'd7}) legal = 0; end
      7'h13: begin
        fi = 1;
        if (f3 inside {3'd1, 3'd5}) begin
          cls = 8;
          if (!(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5))) legal = 0;
        end else cls = 6;
      end
      7'h23: begin cls = 7; fi = 2; if (f3 > 3'd2) legal = 0; end
      7'h33: begin
        fi = 0;
        if (f7 == 7'h00) cls = 9;
        else if (f7 == 7'h20 && f3 inside {3'd0, 3'd5}) cls = 9;
`ifdef RV32M_DEC_EN
        else if (f7 == 7'h01) cls = 12;
`endif
        else legal = 0;
      end
      7'h0F: begin cls = 10; fi = 1; end
      7'h73: begin cls = 11; fi = 1; if (f3 != 0) legal = 0; end
      default: legal = 0;
    endcase
    d = '0;
    if (!legal) begin
      d.il = 1'b1;
      return d;
    end
    d.ot  = 13'(1) << cls;
    d.fm  = 6'(1) << fi;
    si    = i;
    sra20 = si >>> 20;
    b     = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    j     = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    case (fi)
      1: d.im = sra20;
      2: d.im = (sra20 & ~32'h1F) | {27'd0, i[11:7]};
      3: d.im = 32'(b) - (b[12] ? 32'h2000 : 32'h0);
      4: d.im = 32'(j) - (j[20] ? 32'h200000 : 32'h0);
      5: d.im = i & 32'hFFFFF000;
      default: d.im = 32'h0;
    endcase
    return d;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic check_state();
    dec_t d;
    chk("out_valid", out_valid, mq.size() > 0);
    chk("out_count", out_count, mq.size());
    if (mq.size() > 0) begin
      d = ref_dec(mq[0].inst);
      chk("head", {out_pc, out_opcode, out_optype, out_fmt, out_funct3, out_funct7,
                   out_rd, out_rs1, out_rs2, out_imm, out_illegal},
          {mq[0].pc, mq[0].inst[6:0], d.ot, d.fm, mq[0].inst[14:12], mq[0].inst[31:25],
           mq[0].inst[11:7], mq[0].inst[19:15], mq[0].inst[24:20], d.im, d.il});
    end
  endtask

  // One clock: predict handshakes from current inputs, advance the model, compare.
  task automatic tick(output bit acc);
    bit push, pop, fl;
    ment_t e;
    chk("in_ready", in_ready, !rst && mq.size() < DEPTH);
    fl   = flush;
    push = in_valid && !rst && mq.size() < DEPTH && !fl;
    pop  = mq.size() > 0 && out_ready && !fl;
    e.pc = in_pc; e.inst = in_inst;
    @(posedge clk);
    #1;
    if (fl) mq.delete();
    else begin
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(e);
    end
    acc = push;
    check_state();
  endtask

  logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h13, 7'h23, 7'h33,
                           7'h0F, 7'h73};
  logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h7F};

  initial begin
    bit acc;
    logic [31:0] r;
    rst = 1'b1; flush = 0; in_valid = 0; out_ready = 0; in_inst = 0; in_pc = 0;
    #12;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_count", out_count, 2'd0);
    chk("rst_imm", out_imm, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    @(negedge clk); rst = 1'b0; #1;

    // Test 1: alu-imm with all-ones immediate
    out_ready = 1; in_valid = 1; in_inst = 32'hFFF10093; in_pc = 32'h100;
    tick(acc);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_optype", out_optype, 13'h0040);
    chk("t1_fmt", out_fmt, 6'b000010);
    chk("t1_rd", out_rd, 5'd1);
    chk("t1_rs1", out_rs1, 5'd2);
    chk("t1_imm", out_imm, 32'hFFFFFFFF);
    chk("t1_pc", out_pc, 32'h100);

    // Test 2: backward branch
    in_inst = 32'hFE000EE3; in_pc = 32'h104;
    tick(acc);
    chk("t2_optype", out_optype, 13'h0010);
    chk("t2_fmt", out_fmt, 6'b001000);
    chk("t2_imm", out_imm, 32'hFFFFFFFC);
    chk("t2_f3", out_funct3, 3'd0);
    in_valid = 0;
    tick(acc);

    // Test 3: fill, hold third, drain in order
    out_ready = 0; in_valid = 1;
    in_inst = 32'h00500113; in_pc = 32'h200; tick(acc);
    in_inst = 32'h00A00193; in_pc = 32'h204; tick(acc);
    chk("t3_count_full", out_count, 2'd2);
    chk("t3_in_ready_full", in_ready, 1'b0);
    in_inst = 32'h00F00213; in_pc = 32'h208; tick(acc);
    chk("t3_third_held", acc, 1'b0);
    chk("t3_head_a", out_pc, 32'h200);
    out_ready = 1;
    tick(acc);
    chk("t3_head_b", out_pc, 32'h204);
    tick(acc);
    chk("t3_third_taken", acc, 1'b1);
    chk("t3_head_c", out_pc, 32'h208);
    in_valid = 0;
    tick(acc);
    chk("t3_drained", out_count, 2'd0);

    // Test 4: flush with a same-cycle offer
    out_ready = 0; in_valid = 1;
    in_inst = 32'h00100093; in_pc = 32'h300; tick(acc);
    in_pc = 32'h304; tick(acc);
    flush = 1; in_pc = 32'h308; tick(acc);
    flush = 0; in_valid = 0;
    chk("t4_count", out_count, 2'd0);
    chk("t4_valid", out_valid, 1'b0);
    chk("t4_in_ready", in_ready, 1'b1);
    tick(acc);
    chk("t4_not_queued", out_count, 2'd0);

    // Test 5: illegal zero word, then RV32M encoding
    in_valid = 1; in_inst = 32'h00000000; in_pc = 32'h400; tick(acc);
    chk("t5_illegal", out_illegal, 1'b1);
    chk("t5_optype", out_optype, 13'h0);
    out_ready = 1; in_inst = 32'h02208033; in_pc = 32'h404; tick(acc);
`ifdef RV32M_DEC_EN
    chk("t5_muldiv", out_optype, 13'h1000);
    chk("t5_muldiv_legal", out_illegal, 1'b0);
`else
    chk("t5_muldiv_illegal", out_illegal, 1'b1);
`endif
    in_valid = 0; tick(acc);

    // Test 6: asynchronous reset mid-cycle
    out_ready = 0; in_valid = 1; in_inst = 32'h00000037; in_pc = 32'h500; tick(acc);
    in_valid = 0;
    chk("t6_count_before", out_count, 2'd1);
    #3 rst = 1'b1;
    #1;
    chk("t6_async_valid", out_valid, 1'b0);
    chk("t6_async_count", out_count, 2'd0);
    chk("t6_async_in_ready", in_ready, 1'b0);
    mq.delete();
    @(negedge clk); rst = 1'b0; #1;
    in_valid = 1; in_pc = 32'h504; tick(acc);
    chk("t6_resume", out_count, 2'd1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      if ($urandom_range(3) == 0) in_inst = r;
      else begin
        in_inst = {r[31:7], ops[$urandom_range(10)]};
        if ($urandom_range(1) == 0) in_inst[31:25] = f7s[$urandom_range(3)];
      end
      in_pc     = $urandom();
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(15) == 0);
      tick(acc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
